// File: rtl/led_blink_gen_pkg.sv
// Shared types and width helpers for the LED blink generator.
// Widths are derived from the blink timing and queue-depth parameters.
package led_blink_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam int unsigned DEF_ON_CYCLES   = 2500000;
  localparam int unsigned DEF_OFF_CYCLES  = 2500000;
  localparam int unsigned DEF_MAX_PENDING = 7;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Timer only ever holds values up to max(ON,OFF)-1; keep at least one bit.
  function automatic int timer_width(input int unsigned on_c, input int unsigned off_c);
    int w;
    w = clog2(max_u(on_c, off_c));
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int pending_width(input int unsigned max_p);
    return clog2(max_p + 1);
  endfunction

  localparam int DEF_TIMER_W = timer_width(DEF_ON_CYCLES, DEF_OFF_CYCLES);

endpackage

// File: rtl/led_blink_gen_cycle_timer.sv
// Loadable down-counter shared by the ON and OFF phases.
// Stops at zero; a reload is the only way to leave zero.
module cycle_timer
  import led_blink_gen_pkg::*;
#(
  parameter int W = DEF_TIMER_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/led_blink_gen.sv
// Turns single-cycle event strobes into visible LED blinks (ON then OFF gap),
// queueing events that arrive mid-blink in a saturating pending counter.
module led_blink_gen
  import led_blink_gen_pkg::*;
#(
  parameter int unsigned ON_CYCLES   = DEF_ON_CYCLES,
  parameter int unsigned OFF_CYCLES  = DEF_OFF_CYCLES,
  parameter int unsigned MAX_PENDING = DEF_MAX_PENDING,
  localparam int PEND_W = pending_width(MAX_PENDING)
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Event,
  output logic              o_LED,
  output logic              o_Busy,
  output logic [PEND_W-1:0] o_Pending,
  output logic              o_Drop
);

  localparam int TMR_W = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              led_q, busy_q, drop_q, drop_d;
  logic              tmr_load, tmr_zero, have_work, start;
  logic [TMR_W-1:0]  tmr_val;

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk_i      (i_Clk),
    .rst_i      (i_Rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    drop_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = ON_LOAD;
    start     = 1'b0;
    have_work = i_Event || (pend_q != '0);

    case (state_q)
      ST_IDLE: start = have_work;
      ST_ON: begin
        if (tmr_zero) begin
          state_d  = ST_OFF;
          tmr_load = 1'b1;
          tmr_val  = OFF_LOAD;
        end
      end
      ST_OFF: begin
        if (tmr_zero) begin
          if (have_work) start = 1'b1;
          else           state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe on the start edge stands in for the queued event it would consume.
    if (start) begin
      state_d  = ST_ON;
      tmr_load = 1'b1;
      tmr_val  = ON_LOAD;
      if (!i_Event) pend_d = pend_q - PEND_W'(1);
    end else if (i_Event) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + PEND_W'(1);
      else                    drop_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      led_q   <= (state_d == ST_ON);
      busy_q  <= (state_d != ST_IDLE);
      drop_q  <= drop_d;
    end
  end

  assign o_LED     = led_q;
  assign o_Busy    = busy_q;
  assign o_Pending = pend_q;
  assign o_Drop    = drop_q;

endmodule
